// File: rtl/keypad_scan_debounce.sv
// Keypad matrix scanner: scan-rate divider, row synchroniser, press/release debounce and key-event FIFO.
// Optional macro KEYPAD_AUTOREPEAT_EN adds timed auto-repeat pushes while a key stays held.
module keypad_scan_debounce #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 10000,
  parameter int DEBOUNCE      = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 8,
  localparam int CW           = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] rowPins,
  output logic [COLS-1:0] colPins,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_ready,
  output logic            overflow
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = $clog2(COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int NW  = $clog2(DEBOUNCE + 2);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int QW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  function automatic logic [CW-1:0] make_code(input logic [RW-1:0] r, input logic [CLW-1:0] c);
    return CW'(r) * CW'(COLS) + CW'(c);
  endfunction

  logic [ROWS-1:0] sync1_q, rs_q;
  logic [DW-1:0]   div_q;
  logic            tick_s;
  state_e          state_q;
  logic [CLW-1:0]  col_q, col_nxt_s;
  logic [RW-1:0]   row_q, low_idx_s;
  logic [NW-1:0]   cnt_q, cnt_inc_s;
  logic            any_low_s, row_low_s;
  logic            push_s;
  logic [CW-1:0]   push_code_s;
  logic [COLS-1:0] colpins_q;

  logic [CW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, rd_q, rd_d;
  logic [QW-1:0]   count_q, count_d, after_pop_s;
  logic            pop_s, full_s, wr_en_s;
  logic            valid_q, valid_d, ovf_q, ovf_d;
  logic [CW-1:0]   code_q, code_d;

  // Two-flop synchroniser; idle rows read high so reset to ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      rs_q    <= '1;
    end else begin
      sync1_q <= rowPins;
      rs_q    <= sync1_q;
    end
  end

  assign tick_s = (div_q == DW'(SCAN_DIV - 1));

  // Scan-rate divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= tick_s ? '0 : div_q + DW'(1);
    end
  end

  // Lowest-index low row of the synchronised sample.
  always_comb begin
    low_idx_s = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      low_idx_s = !rs_q[i] ? RW'(i) : low_idx_s;
    end
  end

  assign any_low_s = ~&rs_q;
  assign row_low_s = !rs_q[row_q];
  assign cnt_inc_s = cnt_q + NW'(1);
  assign col_nxt_s = (col_q == CLW'(COLS - 1)) ? '0 : col_q + CLW'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  logic [HW-1:0] hold_q, hold_inc_s;
  assign hold_inc_s = hold_q + HW'(1);

  // Hold timer: restarts on any tick outside a steady hold, folds back after each periodic repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (tick_s) begin
      if ((state_q == ST_HELD) && row_low_s) begin
        hold_q <= (hold_inc_s == HW'(REPEAT_DELAY + REPEAT_PERIOD)) ? HW'(REPEAT_DELAY) : hold_inc_s;
      end else begin
        hold_q <= '0;
      end
    end else begin
      hold_q <= hold_q;
    end
  end
`endif

  // Push decision for this tick; it lands in the FIFO on the same edge the FSM moves.
  always_comb begin
    push_s      = 1'b0;
    push_code_s = make_code(row_q, col_q);
    if (tick_s) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low_s && (DEBOUNCE == 1)) begin
            push_s      = 1'b1;
            push_code_s = make_code(low_idx_s, col_q);
          end else begin
            push_s = 1'b0;
          end
        end
        ST_DEBOUNCE: push_s = row_low_s && (cnt_inc_s >= NW'(DEBOUNCE));
`ifdef KEYPAD_AUTOREPEAT_EN
        ST_HELD: push_s = row_low_s && ((hold_inc_s == HW'(REPEAT_DELAY)) ||
                                        (hold_inc_s == HW'(REPEAT_DELAY + REPEAT_PERIOD)));
`endif
        default: push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Scan/debounce FSM; acts only on tick cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SCAN;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      colpins_q <= ~COLS'(1);
    end else begin
      colpins_q <= ~(COLS'(1) << col_q);
      if (tick_s) begin
        case (state_q)
          ST_SCAN: begin
            if (any_low_s) begin
              row_q   <= low_idx_s;
              cnt_q   <= NW'(1);
              state_q <= (DEBOUNCE == 1) ? ST_HELD : ST_DEBOUNCE;
            end else begin
              col_q <= col_nxt_s;
            end
          end
          ST_DEBOUNCE: begin
            if (row_low_s) begin
              cnt_q <= cnt_inc_s;
              if (cnt_inc_s >= NW'(DEBOUNCE)) begin
                state_q <= ST_HELD;
              end
            end else begin
              cnt_q   <= '0;
              col_q   <= col_nxt_s;
              state_q <= ST_SCAN;
            end
          end
          ST_HELD: begin
            if (!row_low_s) begin
              cnt_q   <= NW'(1);
              state_q <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (!row_low_s) begin
              if (cnt_inc_s >= NW'(DEBOUNCE)) begin
                cnt_q   <= '0;
                col_q   <= col_nxt_s;
                state_q <= ST_SCAN;
              end else begin
                cnt_q <= cnt_inc_s;
              end
            end else begin
              state_q <= ST_HELD;
            end
          end
          default: state_q <= ST_SCAN;
        endcase
      end
    end
  end

  assign pop_s       = key_ready && (count_q != '0);
  assign full_s      = (count_q == QW'(FIFO_DEPTH));
  assign wr_en_s     = push_s && (!full_s || pop_s);
  assign after_pop_s = count_q - QW'(pop_s);

  // FIFO next state; the head register tracks the entry that will be at the read pointer.
  always_comb begin
    rd_d    = rd_q + PW'(pop_s);
    count_d = after_pop_s + QW'(wr_en_s);
    valid_d = (count_d != '0);
    ovf_d   = ovf_q || (push_s && full_s && !pop_s);
    if (wr_en_s && (after_pop_s == '0)) begin
      code_d = push_code_s;
    end else if (count_d != '0) begin
      code_d = mem_q[rd_d];
    end else begin
      code_d = code_q;
    end
  end

  // FIFO storage and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_q] <= push_code_s;
        wr_q        <= wr_q + PW'(1);
      end
      rd_q    <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign colPins   = colpins_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a keypad matrix model and a key-code scoreboard.
module tb_keypad_scan_debounce;
  localparam int ROWS = 4;
  localparam int COLS = 4;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rowPins;
  logic [3:0]  colPins;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        overflow;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int sb[$];

  keypad_scan_debounce #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4),
    .REPEAT_DELAY(6), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .reset(reset), .rowPins(rowPins), .colPins(colPins),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    rowPins = '1;
    for (int r = 0; r < ROWS; r++) begin
      rowPins[r] = ~|(keys[r*COLS +: COLS] & ~colPins);
    end
  end

  // Scoreboard monitor: every pop is compared with the oldest expected code.
  always @(negedge clk) begin
    if (reset && key_valid && key_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pop: got code %0d, expected no entry", key_code);
      end else begin
        int exp_code;
        exp_code = sb.pop_front();
        if (int'(key_code) != exp_code) begin
          errors++;
          $display("FAIL sb_code: got %0d, expected %0d", key_code, exp_code);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    clocks(4 * n);
  endtask

  // Press starts just after the tick that selects column c; optionally pops on the push edge.
  task automatic press_aligned(input int r, input int c, input bit pop_at_push);
    keys[r*COLS + c] = 1'b1;
    if (pop_at_push) begin
      clocks(11);
      key_ready = 1'b1;
      clocks(1);
      key_ready = 1'b0;
    end else begin
      clocks(12);
    end
    keys = '0;
    ticks(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_colpins", colPins, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_overflow", overflow, 0);

    // Idle scan walk.
    ticks(1);
    chk("scan_hold_col0", colPins, 4'b1110);
    clocks(1); chk("scan_col1", colPins, 4'b1101);
    clocks(4); chk("scan_col2", colPins, 4'b1011);
    clocks(4); chk("scan_col3", colPins, 4'b0111);
    clocks(4); chk("scan_wrap", colPins, 4'b1110);
    clocks(3); chk("scan_no_valid", key_valid, 0);

    // Row2/col1 press, code 9.
    keys[2*COLS + 1] = 1'b1;
    sb.push_back(9);
    ticks(2); chk("deb_not_yet", key_valid, 0);
    ticks(1); chk("deb_valid", key_valid, 1);
    chk("deb_code", key_code, 9);
    key_ready = 1'b1;
    clocks(4);
    chk("deb_popped", key_valid, 0);
    chk("held_frozen_a", colPins, 4'b1101);
    ticks(2); chk("held_frozen_b", colPins, 4'b1101);
    keys = '0;
    ticks(2); chk("release_frozen", colPins, 4'b1101);
    ticks(1); clocks(1);
    chk("release_resume", colPins, 4'b1011);
    clocks(3);

    // Bounce on row0/col3 for two ticks.
    keys[0*COLS + 3] = 1'b1;
    ticks(2);
    keys = '0;
    chk("bounce_no_valid", key_valid, 0);
    ticks(1); chk("bounce_frozen", colPins, 4'b0111);
    clocks(1); chk("bounce_next_col", colPins, 4'b1110);
    chk("bounce_no_push", key_valid, 0);
    clocks(3);

    // Five presses into a depth-4 queue with no consumer.
    key_ready = 1'b0;
    sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(4);
    press_aligned(0, 1, 1'b0);
    press_aligned(0, 2, 1'b0);
    press_aligned(0, 3, 1'b0);
    press_aligned(1, 0, 1'b0);
    press_aligned(1, 1, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", key_valid, 1);
    chk("ovf_head", key_code, 1);
    key_ready = 1'b1;
    clocks(4);
    key_ready = 1'b0;
    chk("drain_valid", key_valid, 0);
    chk("drain_ovf_sticky", overflow, 1);
    chk("drain_sb_empty", sb.size(), 0);

    // Reset mid-debounce with the key still held, then re-debounce.
    keys[0*COLS + 3] = 1'b1;
    ticks(2);
    reset = 1'b0;
    clocks(2);
    chk("mid_rst_colpins", colPins, 4'b1110);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_overflow", overflow, 0);
    key_ready = 1'b1;
    sb.push_back(3);
    if (AR) begin
      sb.push_back(3);
      sb.push_back(3);
    end
    @(negedge clk);
    reset = 1'b1;
    ticks(6); chk("repress_push", key_valid, 1);
    ticks(5); chk("hold_quiet", key_valid, 0);
    ticks(1); chk("hold_plus6", key_valid, AR ? 1 : 0);
    ticks(1); chk("hold_plus7", key_valid, 0);
    ticks(1); chk("hold_plus8", key_valid, AR ? 1 : 0);
    keys = '0;
    ticks(3);
    chk("repress_ovf", overflow, 0);
    chk("repress_sb_empty", sb.size(), 0);

    // Full queue with push and pop on the same edge.
    key_ready = 1'b0;
    sb.push_back(4); sb.push_back(5); sb.push_back(6); sb.push_back(7); sb.push_back(12);
    press_aligned(1, 0, 1'b0);
    press_aligned(1, 1, 1'b0);
    press_aligned(1, 2, 1'b0);
    press_aligned(1, 3, 1'b0);
    press_aligned(3, 0, 1'b1);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_valid", key_valid, 1);
    chk("full_pp_head", key_code, 5);
    key_ready = 1'b1;
    clocks(4);
    key_ready = 1'b0;
    chk("full_pp_drained", key_valid, 0);
    chk("full_pp_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
Parametrised keypad scanner with per-key debounce and a buffered key-event queue. It is the successor to the fixed 4x4 scanning FSM: any ROWS x COLS matrix, internal scan-rate divider, row synchroniser, press/release debounce, and a FIFO so that no presses are lost while the consumer is busy. It sits between the keypad pins and the display/digit-shift logic.

Parameters:
ROWS, 4, number of row inputs (>=1)
COLS, 4, number of driven columns (>=2)
SCAN_DIV, 10000, clk cycles per scan tick (>=2)
DEBOUNCE, 4, consecutive agreeing ticks required to accept a press or a release (>=1)
FIFO_DEPTH, 4, key-event queue entries (power of 2, >=2)
REPEAT_DELAY, 32, ticks held before the first auto-repeat (used only with the optional feature)
REPEAT_PERIOD, 8, ticks between later auto-repeats (used only with the optional feature)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rowPins  input  ROWS  raw row pins, pulled up; low means a pressed key in the driven column
colPins  output  COLS  column drive; active column is 0, all others 1
key_valid  output  1  FIFO non-empty; key_code is valid
key_code  output  CW  head event code = row*COLS+col, where CW=$clog2(ROWS*COLS)
key_ready  input  1  consumer pop; an entry is popped on any clk edge where key_valid&&key_ready
overflow  output  1  sticky; a press was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous): state=SCAN, col=0, colPins=~1 (col0 low), tick counter=0, debounce count=0, FIFO empty, key_valid=0, key_code=0, overflow=0. Synchroniser flops reset to all-ones.
- rowPins pass through a 2-flop synchroniser. All decisions use the synchronised value rs.
- Tick: the divider counts 0..SCAN_DIV-1 and asserts tick for one clk when it reaches SCAN_DIV-1, then wraps to 0. FSM actions occur only on tick cycles.
- SCAN: if any rs bit is low, latch row=lowest low index and col, set cnt=1, and go to DEBOUNCE. If DEBOUNCE==1, push immediately and go to HELD. Otherwise advance col (COLS-1 wraps to 0).
- DEBOUNCE: col frozen. If rs[row] is low, cnt++; when cnt reaches DEBOUNCE, push the code and go to HELD. If rs[row] is high, set cnt=0, advance col, and go to SCAN.
- HELD: col frozen. Other keys are ignored (no rollover). If rs[row] is high, set cnt=1 and go to RELEASE.
- RELEASE: if rs[row] is high, cnt++; when cnt reaches DEBOUNCE, advance col and go to SCAN. If rs[row] is low, go to HELD with no new push.
- colPins is registered and changes on the clk after the tick that changes col.
- Latency: a push on edge N gives key_valid=1 and key_code=code after edge N.
- FIFO behaviour:
  - key_code always shows the head entry.
  - Pop with key_valid=0 is ignored.
  - Push while full with no pop: the new code is dropped and overflow is set until reset.
  - Push and pop on the same edge while full: both succeed, count is unchanged, overflow is not set.
  - Push and pop on the same edge while empty: the push lands and key_valid rises.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. A count register (0..FIFO_DEPTH) distinguishes full from empty.
- Reset asserted mid-press or mid-debounce aborts everything to the reset state. A key still held after reset is re-detected and re-debounced as a new press.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: in HELD, a hold counter runs on ticks. At REPEAT_DELAY ticks after entering HELD from DEBOUNCE, the same code is pushed again. Further pushes follow every REPEAT_PERIOD ticks while the key stays held. The counter is reset on entry to RELEASE. Returning RELEASE->HELD restarts the delay. Repeat pushes follow the same FIFO and overflow rules.
- Undefined: exactly one push per debounced press. REPEAT_* are unused and the hold counter is not synthesised.

Test Plan:
(bench: SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4)
- Release reset, no keys pressed -> colPins cycles 1110,1101,1011,0111,1110, changing every 4 clk; key_valid=0.
- Hold row2 low while col1 is active -> after 3 agreeing ticks, key_code=9 (2*4+1) and key_valid=1; colPins frozen at 1101 until 3 high ticks after release.
- Bounce: row0 low for 2 ticks then high -> no push; scan resumes from the next column.
- 5 distinct presses with key_ready=0 -> codes 1-4 queued in order, 5th dropped, overflow=1; then key_ready=1 for 4 clk -> codes popped in order, key_valid=0, overflow still 1.
- FIFO full, push and pop on the same edge -> count stays 4, head advances, overflow stays 0.
- Pull reset low in DEBOUNCE with key held; release -> outputs at reset values, then the key is re-debounced and yields exactly one push. With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=6, REPEAT_PERIOD=2: holding the key gives pushes at HELD entry +6 and +8 ticks.
